// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : Asynchronous serial transmitter. Accepts a parallel word on a
//                one-cycle request and emits start, data (LSB first),
//                optional parity and one stop bit, each held for a fixed
//                number of clock cycles set by an internal bit-period counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int WORD_LENGTH  = 8,     // data bits per frame, 5..9
  parameter int CLKS_PER_BIT = 16,    // clock cycles per bit period, >= 2
  parameter bit PARITY_EN    = 1'b0,  // insert a parity bit after the data
  parameter bit PARITY_ODD   = 1'b0   // 0: even parity, 1: odd parity
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Transmit,
  input  logic [WORD_LENGTH-1:0] Data,
  output logic                   Tx,
  output logic                   Busy,
  output logic                   Done
);

  // Counter and index widths; the counter needs at least one bit.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(WORD_LENGTH);

  // Terminal values for the bit-period counter and the data-bit index.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Current state of all registers.
  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [WORD_LENGTH-1:0] shift_reg;
  logic                   parity_bit;

  // Next-state values produced by the combinational process.
  state_t                 state_next;
  logic [CNT_W-1:0]       bit_cnt_next;
  logic [IDX_W-1:0]       bit_idx_next;
  logic [WORD_LENGTH-1:0] shift_next;
  logic                   parity_next;
  logic                   tx_next;
  logic                   busy_next;
  logic                   done_next;

  // High in the last cycle of every bit period.
  logic                   bit_end;

  assign bit_end = (bit_cnt == CNT_LAST);

  // State register: reset wins over everything, including a pending request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      Tx         <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      Tx         <= tx_next;
      Busy       <= busy_next;
      Done       <= done_next;
    end
  end

  // Next-state and next-output logic. Tx is computed one cycle ahead so the
  // registered line only moves at bit boundaries.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    tx_next      = Tx;
    busy_next    = Busy;
    done_next    = 1'b0;

    // The bit-period counter free-runs in every non-idle state.
    if (state != S_IDLE) begin
      bit_cnt_next = bit_end ? '0 : bit_cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        tx_next      = 1'b1;
        busy_next    = 1'b0;
        bit_cnt_next = '0;
        bit_idx_next = '0;
        if (Transmit) begin
          // Word and parity are frozen here; later Data changes are ignored.
          shift_next  = Data;
          parity_next = (^Data) ^ PARITY_ODD;
          state_next  = S_START;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          tx_next    = shift_reg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == IDX_LAST) begin
            bit_idx_next = '0;
            if (PARITY_EN) begin
              state_next = S_PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            tx_next      = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          // Busy drops in the same cycle Done pulses, so they never overlap.
          state_next = S_IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next   = S_IDLE;
        bit_cnt_next = '0;
        bit_idx_next = '0;
        tx_next      = 1'b1;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_serializer
//  Description : Three transmitters (no parity, even, odd) share one stimulus
//                stream; a frame-level model predicts each cycle's outputs
//                and a monitor compares them against the DUTs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int WL  = 8;

  logic          Clk      = 1'b0;
  logic          Reset    = 1'b1;
  logic          Transmit = 1'b0;
  logic [WL-1:0] Data     = '0;
  logic [2:0]    tx;
  logic [2:0]    busy;
  logic [2:0]    done;

  typedef struct {
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Per-DUT model state: frame in flight, edge it was accepted on, its word.
  bit            active  [3];
  int            start_e [3];
  logic [WL-1:0] word    [3];

  always #5 Clk = ~Clk;

  uart_tx_serializer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Transmit(Transmit), .Data(Data),
    .Tx(tx[0]), .Busy(busy[0]), .Done(done[0]));

  uart_tx_serializer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .Clk(Clk), .Reset(Reset), .Transmit(Transmit), .Data(Data),
    .Tx(tx[1]), .Busy(busy[1]), .Done(done[1]));

  uart_tx_serializer #(.WORD_LENGTH(WL), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .Clk(Clk), .Reset(Reset), .Transmit(Transmit), .Data(Data),
    .Tx(tx[2]), .Busy(busy[2]), .Done(done[2]));

  // Number of bits in a frame for DUT p.
  function automatic int frame_bits(input int p);
    return 2 + WL + ((p != 0) ? 1 : 0);
  endfunction

  // Bit i of the frame carrying word w on DUT p.
  function automatic logic bit_at(input int p, input logic [WL-1:0] w, input int i);
    if (i == 0)                return 1'b0;
    if (i <= WL)               return w[i-1];
    if (p != 0 && i == WL + 1) return (^w) ^ (p == 2);
    return 1'b1;
  endfunction

  // Predict the outputs seen in the cycle following the current edge.
  task automatic model_edge();
    exp_t e;
    int   t;
    for (int p = 0; p < 3; p++) begin
      if (Reset) begin
        active[p] = 1'b0;
        e.tx[p] = 1'b1; e.busy[p] = 1'b0; e.done[p] = 1'b0;
      end else if (active[p]) begin
        t = edge_n - start_e[p];
        if (t >= frame_bits(p) * CPB) begin
          active[p] = 1'b0;
          e.tx[p] = 1'b1; e.busy[p] = 1'b0; e.done[p] = 1'b1;
        end else begin
          e.tx[p] = bit_at(p, word[p], t / CPB); e.busy[p] = 1'b1; e.done[p] = 1'b0;
        end
      end else if (Transmit) begin
        active[p]  = 1'b1;
        start_e[p] = edge_n;
        word[p]    = Data;
        e.tx[p] = 1'b0; e.busy[p] = 1'b1; e.done[p] = 1'b0;
      end else begin
        e.tx[p] = 1'b1; e.busy[p] = 1'b0; e.done[p] = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock edge: the model sees the inputs present at the edge, then the
  // caller may change inputs safely away from the edge.
  task automatic tick();
    @(posedge Clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [WL-1:0] d);
    Data     = d;
    Transmit = 1'b1;
    tick();
    Transmit = 1'b0;
  endtask

  // Monitor: pops one prediction per cycle and compares each DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < 3; p++) begin
          checks++;
          if ({tx[p], busy[p], done[p]} !== {e.tx[p], e.busy[p], e.done[p]}) begin
            errors++;
            $display("FAIL edge=%0d dut%0d tx/busy/done got %b%b%b expected %b%b%b",
                     edge_n, p, tx[p], busy[p], done[p], e.tx[p], e.busy[p], e.done[p]);
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 3; p++) begin
      active[p] = 1'b0; start_e[p] = 0; word[p] = '0;
    end

    // Reset, then a long idle stretch.
    Reset = 1'b1;
    wait_edges(3);
    Reset = 1'b0;
    wait_edges(50);

    // Single frames: A5 (plain, even, odd parity) and 07.
    send(8'hA5);
    wait_edges(50);
    send(8'h07);
    wait_edges(50);

    // Back-to-back with Transmit held high; Data changes mid-frame.
    Data     = 8'h00;
    Transmit = 1'b1;
    tick();
    Data = 8'hFF;
    wait_edges(45);
    Transmit = 1'b0;
    wait_edges(60);

    // Requests at cycles 5 and 20 of a frame must be ignored.
    send(8'h3C);
    wait_edges(4);
    send(8'hFF);
    wait_edges(14);
    send(8'h81);
    wait_edges(60);

    // Reset during data bit 3, with Transmit high on the reset edge.
    send(8'h5A);
    wait_edges(16);
    Reset    = 1'b1;
    Transmit = 1'b1;
    tick();
    Reset    = 1'b0;
    Transmit = 1'b0;
    wait_edges(3);
    send(8'hC3);
    wait_edges(50);

    // Randomized traffic with occasional resets.
    repeat (2500) begin
      Transmit = ($urandom_range(0, 7) == 0);
      Data     = WL'($urandom);
      Reset    = ($urandom_range(0, 399) == 0);
      tick();
    end
    Reset    = 1'b0;
    Transmit = 1'b0;
    wait_edges(60);

    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
